// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the rr_arb_mux block.
//   clog2 / sel_width : channel-index width helpers (sel_width is never below 1)
//   PRIO_RR / PRIO_FIXED : prio_mode encodings
package rr_arb_mux_pkg;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // A single channel still needs a one-bit index.
    function automatic int unsigned sel_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: round-robin / fixed-priority arbiter holding the last-grant pointer.
//   clk, reset : clock and synchronous active-high reset (pointer -> N-1)
//   req        : per-channel request
//   mode       : PRIO_RR or PRIO_FIXED, applies to this cycle's arbitration
//   advance    : a transfer happens this cycle; pointer takes grant_idx
//   grant      : one-hot winner, zero when no request
//   grant_idx  : index of the winner
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned N = 6,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);
    localparam logic [SELW-1:0] ONE  = SELW'(1);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] cand;
    logic            found;

    // Walk N candidates starting at ptr+1 (or 0 in fixed mode); wrap is an
    // explicit compare against N-1 so non-power-of-2 N works.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (mode == PRIO_FIXED) begin
            cand = '0;
        end else begin
            cand = (ptr_q == LAST) ? '0 : ptr_q + ONE;
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == LAST) ? '0 : cand + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= LAST;
        end else if (advance) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrated selector feeding one registered output word.
//   clk, reset  : clock and synchronous active-high reset
//   prio_mode   : 0 round-robin, 1 fixed priority (index 0 highest)
//   in_valid    : per-channel request
//   in_ready    : per-channel accept, one-hot or zero
//   in_data     : channel i at [i*WIDTH +: WIDTH]
//   out_valid   : output register holds a word
//   out_ready   : downstream accepts
//   out_data    : registered word
//   out_sel     : channel index of out_data
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 6,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prio_mode,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);

    logic             load_en;
    logic             transfer;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] mux_word;

    // The output register can take a word when empty or being drained.
    assign load_en  = !out_valid || out_ready;
    assign transfer = load_en && (|in_valid) && !reset;
    assign in_ready = transfer ? grant : '0;

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (in_valid),
        .mode      (prio_mode),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        mux_word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                mux_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_word;
            out_sel   <= grant_idx;
        end else if (out_ready) begin
            // Drain: data and index hold their last values.
            out_valid <= 1'b0;
        end
    end

endmodule
